// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory-side controller: accepts one access at a time, issues it to memory,
// returns a one-cycle completion. Optional LSU_TIMEOUT_EN adds a load-response watchdog.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  rsp_load_type,
  output logic [1:0]  rsp_offset,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWaitR = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [2:0] TypeB  = 3'b000;
  localparam logic [2:0] TypeH  = 3'b001;
  localparam logic [2:0] TypeW  = 3'b010;
  localparam logic [2:0] TypeBu = 3'b011;
  localparam logic [2:0] TypeHu = 3'b100;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        illegal;
  logic        accept;
  logic        tmo_hit;

  assign accept = req_valid & req_ready;

  always_comb begin
    illegal = 1'b0;
    case (req_type)
      TypeB:   illegal = 1'b0;
      TypeBu:  illegal = req_we;
      TypeH:   illegal = req_addr[0];
      TypeHu:  illegal = req_addr[0] | req_we;
      TypeW:   illegal = |req_addr[1:0];
      default: illegal = 1'b1;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_q;

  // Held at zero outside WAIT_R, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 8'd0;
    end else if (state_q != StWaitR) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  assign tmo_hit = (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          rdata_d = 32'd0;
          err_d   = illegal;
          state_d = illegal ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (mem_gnt) state_d = we_q ? StResp : StWaitR;
      end
      StWaitR: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      type_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      type_q  <= req_type;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign mem_req   = (state_q == StIssue);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};

  always_comb begin
    mem_be = 4'b0000;
    if (mem_req) begin
      case (type_q)
        TypeW:         mem_be = 4'b1111;
        TypeH, TypeHu: mem_be = 4'b0011 << addr_q[1:0];
        TypeB, TypeBu: mem_be = 4'b0001 << addr_q[1:0];
        default:       mem_be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (type_q)
      TypeB:   mem_wdata = {4{wdata_q[7:0]}};
      TypeH:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
  end

  assign rsp_valid     = (state_q == StResp);
  assign rsp_rdata     = rdata_q;
  assign rsp_load_type = type_q;
  assign rsp_offset    = addr_q[1:0];
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed accesses push expected responses, a negedge
// monitor pops and checks them; memory-side outputs are checked inline by the driver.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_load_type;
  logic [1:0]  rsp_offset;
  logic        rsp_err;
  logic        busy;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_load_type (rsp_load_type),
    .rsp_offset    (rsp_offset),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  typ;
    logic [1:0]  off;
    logic        err;
    logic [31:0] acc;
    logic [31:0] lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cyc = 32'd0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every rsp_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want no response pending");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_load_type", {29'd0, rsp_load_type}, {29'd0, mon_e.typ});
        chk("rsp_offset", {30'd0, rsp_offset}, {30'd0, mon_e.off});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic accept(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat, input bit push);
    exp_t e;
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = wdata;
    if (push) begin
      e.rdata = exp_rdata;
      e.typ   = typ;
      e.off   = addr[1:0];
      e.err   = exp_err;
      e.acc   = cyc;
      e.lat   = 32'(lat);
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int busy_low;

    repeat (2) @(negedge clk);
    chk_idle_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // LW 0x100: gnt in first ISSUE cycle, rvalid next cycle.
    mem_gnt = 1'b1;
    accept(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
    chk("lw_mem_req", {31'd0, mem_req}, 32'd1);
    chk("lw_mem_be", {28'd0, mem_be}, 32'hF);
    chk("lw_mem_addr", mem_addr, 32'h100);
    chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    @(negedge clk);

    // SB 0x203, gnt withheld 3 cycles; stray rvalid during ISSUE must be ignored.
    accept(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1'b0, 5, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      chk("sb_mem_req", {31'd0, mem_req}, 32'd1);
      chk("sb_mem_be", {28'd0, mem_be}, 32'b1000);
      chk("sb_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("sb_mem_addr", mem_addr, 32'h200);
      chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
      if (i == 3) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);

    // Illegal accesses: LH misaligned, SHU, illegal type, LW misaligned.
    accept(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    chk("lh_bad_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    accept(1'b1, 3'b100, 32'h100, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
    chk("shu_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    accept(1'b0, 3'b101, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    @(negedge clk);
    accept(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    @(negedge clk);

    // SH 0x302.
    accept(1'b1, 3'b001, 32'h302, 32'h00001234, 32'h0, 1'b0, 2, 1'b1);
    chk("sh_mem_be", {28'd0, mem_be}, 32'b1100);
    chk("sh_mem_wdata", mem_wdata, 32'h12341234);
    chk("sh_mem_addr", mem_addr, 32'h300);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("resp_mem_be", {28'd0, mem_be}, 32'd0);
    @(negedge clk);

    // LBU 0x401, then responses must hold while idle.
    accept(1'b0, 3'b011, 32'h401, 32'h0, 32'h11223344, 1'b0, 3, 1'b1);
    chk("lbu_mem_be", {28'd0, mem_be}, 32'b0010);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_rsp_rdata", rsp_rdata, 32'h11223344);
    chk("hold_rsp_type", {29'd0, rsp_load_type}, 32'd3);
    chk("hold_rsp_offset", {30'd0, rsp_offset}, 32'd1);
    chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // LW 0x500 with rvalid withheld.
`ifdef LSU_TIMEOUT_EN
    accept(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b1, 6, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo_idle", {31'd0, req_ready}, 32'd1);
`else
    accept(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt  = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
    end
    chk("hang_busy_low_cycles", 32'(busy_low), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // Reset in WAIT_R, then a stale rvalid.
    accept(1'b0, 3'b010, 32'h600, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk_idle_reset("post_rst");
    @(negedge clk);

    chk("pending_rsp", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
